// File: rtl/wb_lane_serializer_if.sv
// Bus bundle between the MAC array (master) and the write-back serializer (slave).
interface wb_lane_serializer_if #(
  parameter int LANES  = 4,
  parameter int DW     = 18,
  parameter int RAM_DW = 32,
  parameter int AW     = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*DW-1:0]   lane_data;
  logic                  addr_clr;
  logic                  we_n;
  logic [AW-1:0]         w_addr;
  logic [RAM_DW-1:0]     dataRAM;
  logic                  busy;
  logic                  done;

  modport master (
    output in_valid, lane_data, addr_clr,
    input  in_ready, we_n, w_addr, dataRAM, busy, done
  );

  modport slave (
    input  in_valid, lane_data, addr_clr,
    output in_ready, we_n, w_addr, dataRAM, busy, done
  );
endinterface

// File: rtl/wb_lane_serializer.sv
// Write-back serializer: one LANES-wide burst in, one RAM word per cycle out at a wrapping pointer.
// Optional macro WB_SIGN_EXT_EN: sign-extend lane results into the RAM word instead of zero-extending.
module wb_lane_serializer #(
  parameter int LANES     = 4,
  parameter int DW        = 18,
  parameter int RAM_DW    = 32,
  parameter int AW        = 8,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 64
) (
  input logic              clk,
  input logic              rst,
  wb_lane_serializer_if.slave bus
);

  localparam int             IW       = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IW-1:0]  LAST_IDX = IW'(LANES - 1);
  localparam logic [AW-1:0]  BASE     = AW'(BASE_ADDR);
  localparam logic [AW-1:0]  TOP      = AW'(BASE_ADDR + DEPTH - 1);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t                state;
  logic [IW-1:0]         idx;
  logic [AW-1:0]         ptr;
  logic [LANES*DW-1:0]   buffer;
  logic [LANES*DW-1:0]   shifted;
  logic                  we_n_q;
  logic [RAM_DW-1:0]     data_q;
  logic                  done_q;
  logic                  last;
  logic                  in_ready;
  logic                  accept;

  function automatic logic [RAM_DW-1:0] ext(input logic [DW-1:0] v);
    logic [RAM_DW-1:0] r;
`ifdef WB_SIGN_EXT_EN
    r = {RAM_DW{v[DW-1]}};
`else
    r = '0;
`endif
    r[DW-1:0] = v;
    return r;
  endfunction

  assign last     = (state == WRITE) && (idx == LAST_IDX);
  assign in_ready = (state == IDLE) || last;
  assign accept   = bus.in_valid && in_ready;
  // Buffer is consumed lane 0 first by shifting down; the next lane always sits at the bottom.
  assign shifted  = buffer >> DW;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      ptr    <= BASE;
      buffer <= '0;
      we_n_q <= 1'b1;
      data_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= last;

      if (bus.addr_clr)
        ptr <= BASE;
      else if (state == WRITE)
        ptr <= (ptr == TOP) ? BASE : ptr + 1'b1;

      if (accept) begin
        state  <= WRITE;
        idx    <= '0;
        buffer <= bus.lane_data;
        we_n_q <= 1'b0;
        data_q <= ext(bus.lane_data[DW-1:0]);
      end else if (last || state == IDLE) begin
        state  <= IDLE;
        idx    <= '0;
        we_n_q <= 1'b1;
        data_q <= '0;
      end else begin
        idx    <= idx + 1'b1;
        buffer <= shifted;
        data_q <= ext(shifted[DW-1:0]);
      end
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.we_n     = we_n_q;
  assign bus.w_addr   = ptr;
  assign bus.dataRAM  = data_q;
  assign bus.busy     = (state == WRITE);
  assign bus.done     = done_q;

endmodule

// File: tb/tb_wb_lane_serializer.sv
// Randomised self-checking bench for wb_lane_serializer against a queue-based write model.
module tb_wb_lane_serializer;

  localparam int LANES = 4;
  localparam int DW    = 18;
  localparam int RDW   = 32;
  localparam int AW    = 8;
  localparam int BASE  = 0;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  wb_lane_serializer_if #(.LANES(LANES), .DW(DW), .RAM_DW(RDW), .AW(AW)) bus ();

  wb_lane_serializer #(
    .LANES(LANES), .DW(DW), .RAM_DW(RDW), .AW(AW), .BASE_ADDR(BASE), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: words still owed to the RAM (head = word being written now),
  // the address the next write goes to, and whether a burst just finished.
  logic [RDW-1:0] pend[$];
  int             mptr;
  bit             mdone;

  function automatic logic [RDW-1:0] mext(input logic [DW-1:0] v);
`ifdef WB_SIGN_EXT_EN
    return (v[DW-1]) ? (32'hFFFF_FFFF - 32'h3_FFFF + 32'(v)) : 32'(v);
`else
    return 32'(v);
`endif
  endfunction

  function automatic logic [43:0] expv();
    logic [RDW-1:0] d;
    d = (pend.size() != 0) ? pend[0] : 32'h0;
    return {pend.size() == 0, 8'(mptr), d, pend.size() <= 1, pend.size() != 0, mdone};
  endfunction

  function automatic logic [43:0] obs();
    return {bus.we_n, bus.w_addr, bus.dataRAM, bus.in_ready, bus.busy, bus.done};
  endfunction

  function automatic logic [71:0] rand72();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[71:0];
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, land 1 time unit after it.
  task automatic tick(input logic v, input logic [71:0] d, input logic clr, output logic acc);
    @(negedge clk);
    bus.in_valid  = v;
    bus.lane_data = d;
    bus.addr_clr  = clr;
    acc   = v && (pend.size() <= 1);
    mdone = (pend.size() == 1);
    if (pend.size() != 0) begin
      void'(pend.pop_front());
      if (clr) mptr = BASE;
      else     mptr = (mptr == BASE + DEPTH - 1) ? BASE : mptr + 1;
    end else if (clr) begin
      mptr = BASE;
    end
    if (acc)
      for (int i = 0; i < LANES; i++) pend.push_back(mext(d[i*DW +: DW]));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic acc;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.we_n, bus.w_addr, bus.dataRAM, bus.busy, bus.done} !== {1'b1, 8'h00, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_hold: got %h expected %h", {bus.we_n, bus.w_addr, bus.dataRAM, bus.busy, bus.done},
               {1'b1, 8'h00, 32'h0, 1'b0, 1'b0});
    end
    rst = 1'b0;
    tick(1'b1, rand72(), 1'b0, acc);
    tick(1'b0, '0, 1'b0, acc);
    checks++;
    if (obs() !== expv()) begin
      errors++;
      $display("FAIL pre_abort: got %h expected %h", obs(), expv());
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.we_n, bus.w_addr, bus.dataRAM, bus.busy, bus.done} !== {1'b1, 8'h00, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_midrun: got %h expected %h", {bus.we_n, bus.w_addr, bus.dataRAM, bus.busy, bus.done},
               {1'b1, 8'h00, 32'h0, 1'b0, 1'b0});
    end
    pend.delete();
    mptr  = BASE;
    mdone = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.busy} !== 2'b10 || obs() !== expv()) begin
      errors++;
      $display("FAIL reset_release: got %h expected %h", obs(), expv());
    end
  endtask

  task automatic test_burst();
    logic acc;
    logic [71:0] d;
    d = {18'd4, 18'd3, 18'd2, 18'd1};
    tick(1'b1, d, 1'b0, acc);
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (bus.we_n !== 1'b0 || bus.w_addr !== 8'(j) || bus.dataRAM !== 32'(j + 1) ||
          bus.in_ready !== (j == 3) || bus.done !== 1'b0 || obs() !== expv()) begin
        errors++;
        $display("FAIL burst_write%0d: got %h expected %h", j, obs(), expv());
      end
      tick(1'b0, '0, 1'b0, acc);
    end
    checks++;
    if (bus.done !== 1'b1 || bus.we_n !== 1'b1 || bus.in_ready !== 1'b1 || obs() !== expv()) begin
      errors++;
      $display("FAIL burst_done: got %h expected %h", obs(), expv());
    end
    tick(1'b0, '0, 1'b0, acc);
    checks++;
    if (bus.done !== 1'b0 || obs() !== expv()) begin
      errors++;
      $display("FAIL burst_done_single: got %h expected %h", obs(), expv());
    end
  endtask

  task automatic test_back_to_back();
    logic acc;
    logic [71:0] da, db;
    int dones;
    da = rand72();
    db = rand72();
    dones = 0;
    tick(1'b0, '0, 1'b1, acc);
    tick(1'b1, da, 1'b0, acc);
    for (int c = 0; c < 8; c++) begin
      dones += int'(bus.done);
      checks++;
      if (bus.we_n !== 1'b0 || bus.w_addr !== 8'(c) || obs() !== expv()) begin
        errors++;
        $display("FAIL b2b_cycle%0d: got %h expected %h", c, obs(), expv());
      end
      if (c < 3)       tick(1'b1, da, 1'b0, acc);
      else if (c == 3) tick(1'b1, db, 1'b0, acc);
      else             tick(1'b0, '0, 1'b0, acc);
    end
    dones += int'(bus.done);
    checks++;
    if (dones != 2 || bus.we_n !== 1'b1 || obs() !== expv()) begin
      errors++;
      $display("FAIL b2b_end: done count %0d expected 2, got %h expected %h", dones, obs(), expv());
    end
    tick(1'b0, '0, 1'b0, acc);
  endtask

  task automatic test_addr_clr();
    logic acc;
    int clr_at[3];
    int addrs[3][4];
    clr_at = '{2, 4, 1};
    addrs  = '{'{8, 9, 10, 0}, '{1, 2, 3, 4}, '{5, 6, 0, 1}};
    for (int r = 0; r < 3; r++) begin
      tick(1'b1, rand72(), 1'b0, acc);
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (bus.we_n !== 1'b0 || bus.w_addr !== 8'(addrs[r][c]) || obs() !== expv()) begin
          errors++;
          $display("FAIL clr_row%0d_write%0d: got addr %0d expected %0d, got %h expected %h",
                   r, c, bus.w_addr, addrs[r][c], obs(), expv());
        end
        tick(1'b0, '0, (c == clr_at[r]), acc);
      end
    end
    checks++;
    if (bus.w_addr !== 8'd2 || obs() !== expv()) begin
      errors++;
      $display("FAIL clr_final_ptr: got %0d expected 2", bus.w_addr);
    end
  endtask

  task automatic test_wrap();
    logic acc;
    logic hold;
    logic [71:0] d;
    int addrs[4];
    addrs = '{62, 63, 0, 1};
    d = rand72();
    for (int i = 0; i < 61; i++) begin
      tick(i < 60, d, 1'b0, acc);
      if (acc) d = rand72();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL wrap_fill%0d: got %h expected %h", i, obs(), expv());
      end
    end
    hold = 1'b0;
    tick(1'b1, rand72(), 1'b0, acc);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (bus.w_addr !== 8'(addrs[c]) || bus.we_n !== 1'b0 || obs() !== expv()) begin
        errors++;
        $display("FAIL wrap_write%0d: got addr %0d expected %0d", c, bus.w_addr, addrs[c]);
      end
      tick(1'b0, '0, hold, acc);
    end
    tick(1'b0, '0, 1'b1, acc);
    tick(1'b1, rand72(), 1'b0, acc);
    checks++;
    if (bus.w_addr !== 8'd0 || bus.we_n !== 1'b0 || obs() !== expv()) begin
      errors++;
      $display("FAIL wrap_after_clr: got addr %0d expected 0", bus.w_addr);
    end
    repeat (4) tick(1'b0, '0, 1'b0, acc);
  endtask

  task automatic test_sign_ext();
    logic acc;
    logic [71:0] d;
    logic [RDW-1:0] want;
`ifdef WB_SIGN_EXT_EN
    want = 32'hFFFE_0000;
`else
    want = 32'h0002_0000;
`endif
    d = {18'h1FFFF, 18'h3FFFF, 18'h00001, 18'h20000};
    tick(1'b1, d, 1'b0, acc);
    checks++;
    if (bus.dataRAM !== want || obs() !== expv()) begin
      errors++;
      $display("FAIL sign_ext_lane0: got %h expected %h", bus.dataRAM, want);
    end
    for (int c = 1; c < 4; c++) begin
      tick(1'b0, '0, 1'b0, acc);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL sign_ext_lane%0d: got %h expected %h", c, obs(), expv());
      end
    end
    tick(1'b0, '0, 1'b0, acc);
  endtask

  task automatic test_random();
    logic acc, v, hold;
    logic [71:0] d;
    hold = 1'b0;
    v = 1'b0;
    d = rand72();
    for (int i = 0; i < 300; i++) begin
      if (!hold) v = ($urandom_range(0, 3) != 0);
      tick(v, d, ($urandom_range(0, 19) == 0), acc);
      hold = v && !acc;
      if (acc) d = rand72();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL random_cycle%0d: got %h expected %h", i, obs(), expv());
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.lane_data = '0;
    bus.addr_clr  = 1'b0;
    mptr  = BASE;
    mdone = 1'b0;
    test_reset();
    test_burst();
    test_back_to_back();
    test_addr_clr();
    test_wrap();
    test_sign_ext();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
